framebuffer_arbiter: RTL
========================

# framebuffer_arbiter

Shares one port of the 96k × 16-bit dual-port framebuffer between two requesters with round-robin arbitration. Also contains a hardware clear sequencer that fills the whole framebuffer with one colour. Sits between the drawing-side masters (CPU bus bridge, blitter) and framebuffer port A. Port B stays dedicated to video scan-out.

## Interface
- ADDR_WIDTH, 17, word address width of the framebuffer
- DATA_WIDTH, 16, pixel word width
- FB_WORDS, 98304, number of valid framebuffer words; addresses ≥ FB_WORDS are out of range

Ports:
- clk  in  1  single clock; also drives framebuffer clkA
- resetN  in  1  asynchronous, active-low reset
- req0Valid / req1Valid  in  1  requester N presents a command
- req0Ready / req1Ready  out  1  command accepted this cycle (combinational grant)
- req0Write / req1Write  in  1  1 = write, 0 = read
- req0Address / req1Address  in  ADDR_WIDTH  word address
- req0Data / req1Data  in  DATA_WIDTH  write data
- rsp0Valid / rsp1Valid  out  1  read data valid for requester N (one-cycle pulse)
- rsp0Data / rsp1Data  out  DATA_WIDTH  read data
- clearStart  in  1  one-cycle pulse that starts a full clear
- clearColor  in  DATA_WIDTH  fill value, sampled when clearStart is accepted
- clearBusy  out  1  clear in progress
- memAddress  out  ADDR_WIDTH  to framebuffer addressA (registered)
- memDataOut  out  DATA_WIDTH  to framebuffer dataInA (registered)
- memWriteEnable  out  1  to framebuffer writeEnableA (registered)
- memDataIn  in  DATA_WIDTH  from framebuffer dataOutA; valid one cycle after the read command

## Operation
- States: IDLE, CLEAR.
- **IDLE arbitration**
  - One valid: that requester is granted.
  - Both valid: grant the requester not granted last (lastGrant register).
  - Grant drives reqNReady high in the same cycle. A transfer occurs when valid and ready are both high at a clock edge.
  - Requesters hold valid and the command stable until ready is seen. Valid must not depend on ready.
- **Accepted command**
  - Registered onto memAddress, memDataOut and memWriteEnable (= write) for exactly one cycle.
  - In cycles with no accepted command, memWriteEnable = 0 and memAddress/memDataOut hold their values.
- **Read response**
  - rspNValid pulses in the cycle after the command cycle, to the issuing requester only.
  - rspNData = memDataIn in that cycle. rspNData of the non-pulsing requester is 0.
- **Out-of-range address (≥ FB_WORDS)**
  - Still consumes a grant.
  - A write is dropped (memWriteEnable stays 0).
  - A read still produces rspNValid, with rspNData = 0.
- **Clear start**
  - clearStart is accepted only in IDLE.
  - In that cycle both readies are forced low. clearColor is latched and the state becomes CLEAR.
  - clearStart in CLEAR is ignored.
- **CLEAR**
  - Both readies low.
  - Address counter runs 0..FB_WORDS-1, one write per cycle: memWriteEnable = 1, memDataOut = latched colour.
  - After address FB_WORDS-1 is issued, the state returns to IDLE.
- **Read response across a clear start:** a read accepted in the cycle before clearStart still returns normally.
- **Reset values:** all registered outputs are 0; state = IDLE; lastGrant = 1, so requester 0 wins the first tie; clear counter 0. While resetN is low, readies are 0.
- **Reset during CLEAR:** the clear aborts immediately. Memory contents are left partially cleared; no resume.

## Timing
- Accept at edge t → command on memory pins during cycle t..t+1 → framebuffer samples at edge t+1 → rspNValid/rspNData valid during cycle t+1..t+2.
- Read latency: 2 edges from acceptance to data.
- Throughput: one access per cycle. Back-to-back reads from alternating requesters pipeline with no bubbles.
- **Clear:**
  - clearStart sampled at edge s.
  - clearBusy = 1 from edge s through the cycle in which address FB_WORDS-1 is on memAddress. That is FB_WORDS cycles of memory writes.
  - Requests can be granted in the cycle after the last clear write command.
- No combinational path from memDataIn to any ready or mem* output.

## Test plan
- **Single read:** req0 reads address 0x00010 with framebuffer word = 0xBEEF → memAddress = 0x00010 and memWriteEnable = 0 one cycle after acceptance; rsp0Valid pulses next cycle with rsp0Data = 0xBEEF; rsp1Valid stays 0.
- **Contention:** both requesters continuously valid for 6 cycles after reset → grants go 0,1,0,1,0,1 and memory sees one command per cycle.
- **Out of range:** req1 writes 0x1234 to address 0x18000 → memWriteEnable stays 0. req1 reads 0x1FFFF → rsp1Valid pulses with rsp1Data = 0x0000.
- **Clear:** clearStart with clearColor = 0x001F, FB_WORDS set to 16 in the bench → 16 consecutive writes to addresses 0..15 with data 0x001F; clearBusy high for exactly 16 cycles; pending req0Valid is held off and granted in the first cycle after the clear.
- **Clear start collision:** req0 read accepted in cycle k, clearStart in cycle k+1 → rsp0 read data still returned; clearStart pulse repeated mid-clear → ignored, clear length unchanged.
- **Reset mid-clear:** resetN driven low after 5 clear writes → clearBusy, memWriteEnable, memAddress and rspNValid all 0 while reset is low; after release, state is IDLE and requests are granted.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// Round-robin sharing of framebuffer port A between two drawing masters, plus a
// sequencer that fills the whole framebuffer with one colour at one word per cycle.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int FB_WORDS   = 98304
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic                  req0Write,
  input  logic [ADDR_WIDTH-1:0] req0Address,
  input  logic [DATA_WIDTH-1:0] req0Data,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic                  req1Write,
  input  logic [ADDR_WIDTH-1:0] req1Address,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic                  rsp0Valid,
  output logic [DATA_WIDTH-1:0] rsp0Data,
  output logic                  rsp1Valid,
  output logic [DATA_WIDTH-1:0] rsp1Data,
  input  logic                  clearStart,
  input  logic [DATA_WIDTH-1:0] clearColor,
  output logic                  clearBusy,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memDataOut,
  output logic                  memWriteEnable,
  input  logic [DATA_WIDTH-1:0] memDataIn
);

  // One extra counter bit so the clear counter can reach FB_WORDS itself.
  localparam logic [ADDR_WIDTH:0] FB_LIMIT  = (ADDR_WIDTH+1)'(FB_WORDS);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state_r;
  state_t                nextState_s;
  logic                  lastGrant_r;
  logic [ADDR_WIDTH:0]   clearCount_r;
  logic [DATA_WIDTH-1:0] clearColor_r;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  clearAccept_s;
  logic                  clearIssue_s;
  logic [ADDR_WIDTH-1:0] cmdAddress_s;
  logic [DATA_WIDTH-1:0] cmdData_s;
  logic                  cmdWrite_s;
  logic                  cmdInRange_s;
  logic [ADDR_WIDTH-1:0] memAddress_r;
  logic [DATA_WIDTH-1:0] memDataOut_r;
  logic                  memWriteEnable_r;
  logic                  cmdRead0_r;
  logic                  cmdRead1_r;
  logic                  cmdOor_r;
  logic                  rsp0Valid_r;
  logic                  rsp1Valid_r;
  logic                  rspOor_r;

  function automatic logic inRange(input logic [ADDR_WIDTH-1:0] address);
    return ({1'b0, address} < FB_LIMIT);
  endfunction

  // Grant selection; lastGrant_r = 1 means requester 1 was served last.
  always_comb begin
    grant0_s      = 1'b0;
    grant1_s      = 1'b0;
    clearAccept_s = 1'b0;
    if (resetN && (state_r == IDLE)) begin
      if (clearStart) begin
        clearAccept_s = 1'b1;
      end else if (req0Valid && req1Valid) begin
        grant0_s = lastGrant_r;
        grant1_s = ~lastGrant_r;
      end else begin
        grant0_s = req0Valid;
        grant1_s = req1Valid;
      end
    end else begin
      clearAccept_s = 1'b0;
    end
  end

  // Next state: CLEAR stays until the last fill address has been on the pins.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (clearAccept_s) nextState_s = CLEAR;
        else               nextState_s = IDLE;
      end
      CLEAR: begin
        if (clearCount_r == FB_LIMIT) nextState_s = IDLE;
        else                          nextState_s = CLEAR;
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Command selection; address 0 of a fill goes out on the accepting edge itself.
  always_comb begin
    cmdAddress_s = memAddress_r;
    cmdData_s    = memDataOut_r;
    cmdWrite_s   = 1'b0;
    cmdInRange_s = 1'b1;
    clearIssue_s = 1'b0;
    if (clearAccept_s) begin
      cmdAddress_s = {ADDR_WIDTH{1'b0}};
      cmdData_s    = clearColor;
      cmdWrite_s   = 1'b1;
    end else if ((state_r == CLEAR) && (clearCount_r != FB_LIMIT)) begin
      clearIssue_s = 1'b1;
      cmdAddress_s = clearCount_r[ADDR_WIDTH-1:0];
      cmdData_s    = clearColor_r;
      cmdWrite_s   = 1'b1;
    end else if (grant0_s) begin
      cmdInRange_s = inRange(req0Address);
      cmdAddress_s = req0Address;
      cmdData_s    = req0Data;
      cmdWrite_s   = req0Write & cmdInRange_s;
    end else if (grant1_s) begin
      cmdInRange_s = inRange(req1Address);
      cmdAddress_s = req1Address;
      cmdData_s    = req1Data;
      cmdWrite_s   = req1Write & cmdInRange_s;
    end else begin
      cmdWrite_s = 1'b0;
    end
  end

  // State, round-robin history and fill bookkeeping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE;
      lastGrant_r  <= 1'b1;
      clearCount_r <= {(ADDR_WIDTH+1){1'b0}};
      clearColor_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= nextState_s;
      if (grant0_s)      lastGrant_r <= 1'b0;
      else if (grant1_s) lastGrant_r <= 1'b1;
      else               lastGrant_r <= lastGrant_r;
      if (clearAccept_s) begin
        clearCount_r <= COUNT_ONE;
        clearColor_r <= clearColor;
      end else if (clearIssue_s) begin
        clearCount_r <= clearCount_r + COUNT_ONE;
      end else if (state_r == CLEAR) begin
        clearCount_r <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
        clearCount_r <= clearCount_r;
      end
    end
  end

  // Memory port registers; address and data hold when nothing is issued.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      memAddress_r     <= {ADDR_WIDTH{1'b0}};
      memDataOut_r     <= {DATA_WIDTH{1'b0}};
      memWriteEnable_r <= 1'b0;
    end else begin
      memAddress_r     <= cmdAddress_s;
      memDataOut_r     <= cmdData_s;
      memWriteEnable_r <= cmdWrite_s;
    end
  end

  // Read tracking: command cycle first, then the cycle the framebuffer data is valid.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cmdRead0_r  <= 1'b0;
      cmdRead1_r  <= 1'b0;
      cmdOor_r    <= 1'b0;
      rsp0Valid_r <= 1'b0;
      rsp1Valid_r <= 1'b0;
      rspOor_r    <= 1'b0;
    end else begin
      cmdRead0_r  <= grant0_s & ~req0Write;
      cmdRead1_r  <= grant1_s & ~req1Write;
      cmdOor_r    <= ~cmdInRange_s;
      rsp0Valid_r <= cmdRead0_r;
      rsp1Valid_r <= cmdRead1_r;
      rspOor_r    <= cmdOor_r;
    end
  end

  assign req0Ready      = grant0_s;
  assign req1Ready      = grant1_s;
  assign clearBusy      = (state_r == CLEAR);
  assign memAddress     = memAddress_r;
  assign memDataOut     = memDataOut_r;
  assign memWriteEnable = memWriteEnable_r;
  assign rsp0Valid      = rsp0Valid_r;
  assign rsp1Valid      = rsp1Valid_r;
  // Out-of-range reads answer zero instead of whatever the RAM drives.
  assign rsp0Data = (rsp0Valid_r && !rspOor_r) ? memDataIn : {DATA_WIDTH{1'b0}};
  assign rsp1Data = (rsp1Valid_r && !rspOor_r) ? memDataIn : {DATA_WIDTH{1'b0}};

endmodule
